// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: segment LUT,
// scan state encoding, buffer record and small helpers.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (see seg_scan_ctrl).
package seg_pkg;

    // All segments off (active-high bus)
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Hex 0..F to segments g..a; entry [n] is the pattern for nibble n
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Scan state: dark, blanking gap, or driving a digit
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } seg_state_e;

    // One display value: four nibbles plus a decimal point per digit
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
    } seg_buf_t;

    // One-hot digit enable for a 2-bit digit index
    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = 4'b0001;
            2'd1:    sel = 4'b0010;
            2'd2:    sel = 4'b0100;
            2'd3:    sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Digits to suppress as leading zeros: a digit is blanked when it and every
    // higher nibble are zero and its own dp is clear; digit 0 is never blanked.
    function automatic logic [3:0] lead_zero_mask(input seg_buf_t b);
        logic [3:0] nib_zero;
        logic [3:0] run_zero;
        for (int i = 0; i < 4; i++) begin
            nib_zero[i] = (b.data[4*i +: 4] == 4'h0);
        end
        run_zero[3] = nib_zero[3];
        run_zero[2] = run_zero[3] & nib_zero[2];
        run_zero[1] = run_zero[2] & nib_zero[1];
        run_zero[0] = run_zero[1] & nib_zero[0];
        return run_zero & ~b.dp & 4'b1110;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment (g..a) decoder built on SEG7_LUT.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_LUT[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller.
// Each digit slot is DWELL cycles: BLANK_CYC dark cycles, then the digit is
// driven. New values enter a shadow buffer over valid/ready and are promoted to
// the active buffer only at a frame boundary (or at once while idle).
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 125
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        LOAD_VALID,
    input  logic [15:0] LOAD_DATA,
    input  logic [3:0]  LOAD_DP,
    output logic        LOAD_READY,
    output logic [7:0]  SEGMENT,
    output logic [3:0]  DIGIT_SEL,
    output logic        FRAME_DONE
);

    localparam int DWELL = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(DWELL - 1);

    seg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    seg_buf_t         active_q, active_d;
    seg_buf_t         shadow_q, shadow_d;
    logic             ready_q, ready_d;

    logic [7:0]       seg_q, seg_d;
    logic [3:0]       sel_q, sel_d;
    logic             fd_q, fd_d;

    logic             transfer_s;
    logic             promote_s;
    logic [3:0]       nib_s;
    logic             dp_s;
    logic [6:0]       pat_s;

    // Scan sequencer: next state, slot counter and digit index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!ENABLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_BLANK_END) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = BLANK;
                    end
                end
                DRIVE: begin
                    if (cnt_q == CNT_SLOT_END) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Shadow/active buffering: accept into shadow, promote at frame end or idle
    always_comb begin
        transfer_s = LOAD_VALID & ready_q;
        promote_s  = ~ready_q & (fd_q | (state_q == IDLE));
        shadow_d   = shadow_q;
        active_d   = active_q;
        ready_d    = ready_q;
        if (promote_s) begin
            active_d = shadow_q;
            ready_d  = 1'b1;
        end else if (transfer_s) begin
            shadow_d.data = LOAD_DATA;
            shadow_d.dp   = LOAD_DP;
            ready_d       = 1'b0;
        end else begin
            ready_d = ready_q;
        end
    end

    // Select the nibble and dp of the digit about to be driven
    always_comb begin
        case (idx_d)
            2'd0:    nib_s = active_d.data[3:0];
            2'd1:    nib_s = active_d.data[7:4];
            2'd2:    nib_s = active_d.data[11:8];
            2'd3:    nib_s = active_d.data[15:12];
            default: nib_s = 4'h0;
        endcase
        dp_s = active_d.dp[idx_d];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nib_s),
        .seg_o    (pat_s)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [3:0] lz_mask_s;
    assign lz_mask_s = lead_zero_mask(active_d);
`endif

    // Output pattern for the upcoming cycle so outputs align with the state
    always_comb begin
        seg_d = SEG_OFF;
        sel_d = 4'b0000;
        fd_d  = 1'b0;
        if (state_d == DRIVE) begin
            sel_d = digit_onehot(idx_d);
            fd_d  = (idx_d == 2'd3) && (cnt_d == CNT_SLOT_END);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (lz_mask_s[idx_d]) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = {dp_s, pat_s};
            end
`else
            seg_d = {dp_s, pat_s};
`endif
        end else begin
            seg_d = SEG_OFF;
            sel_d = 4'b0000;
            fd_d  = 1'b0;
        end
    end

    // Sequencer state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Display buffers and handshake ready flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active_q <= '0;
            shadow_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            ready_q  <= ready_d;
        end
    end

    // Registered display pins and frame pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_q <= SEG_OFF;
            sel_q <= 4'b0000;
            fd_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
            fd_q  <= fd_d;
        end
    end

    assign SEGMENT    = seg_q;
    assign DIGIT_SEL  = sel_q;
    assign FRAME_DONE = fd_q;
    assign LOAD_READY = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (CLK_FREQ=1000, SCAN_HZ=100,
// BLANK_CYC=2, so a 10-cycle slot and a 40-cycle frame).
module tb_seg_scan_ctrl;

    localparam int DWELL = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DWELL;

    typedef logic [3:0][7:0] segs_t;
    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        segs_t       seg;
    } vec_t;

    logic        CLK;
    logic        RST_N;
    logic        ENABLE;
    logic        LOAD_VALID;
    logic [15:0] LOAD_DATA;
    logic [3:0]  LOAD_DP;
    logic        LOAD_READY;
    logic [7:0]  SEGMENT;
    logic [3:0]  DIGIT_SEL;
    logic        FRAME_DONE;

    int    n_cmp = 0;
    int    n_bad = 0;
    vec_t  tbl [10];
    segs_t sb_q [$];

    seg_scan_ctrl #(
        .CLK_FREQ  (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENABLE     (ENABLE),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_DP    (LOAD_DP),
        .LOAD_READY (LOAD_READY),
        .SEGMENT    (SEGMENT),
        .DIGIT_SEL  (DIGIT_SEL),
        .FRAME_DONE (FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_fd(input string name);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge CLK);
            if (FRAME_DONE === 1'b1) return;
        end
        chk({name, "_fd_timeout"}, 32'(FRAME_DONE), 32'd1);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (LOAD_READY === 1'b1) return;
            @(negedge CLK);
        end
        chk({name, "_ready_timeout"}, 32'(LOAD_READY), 32'd1);
    endtask

    // Current sample is the first BLANK cycle of digit 0; checks 40 cycles,
    // ending on the FRAME_DONE sample. Releases any held LOAD_VALID after 1 cycle.
    task automatic check_frame(input string name);
        segs_t       segs;
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        segs = sb_q.pop_front();
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < DWELL; p++) begin
                if (s != 0 || p != 0) @(negedge CLK);
                if (s == 0 && p == 1) LOAD_VALID = 1'b0;
                if (p < BLANK) exp = 32'd0;
                else exp = 32'({(s == 3 && p == DWELL - 1), 4'(1 << s), segs[s]});
                chk(name, 32'({FRAME_DONE, DIGIT_SEL, SEGMENT}), exp);
            end
        end
    endtask

    task automatic drive_load(input int i);
        LOAD_DATA  = tbl[i].data;
        LOAD_DP    = tbl[i].dp;
        LOAD_VALID = 1'b1;
        sb_q.push_back(tbl[i].seg);
    endtask

    // Full load flow: accept, ready low until promotion, then show one frame
    task automatic load_vec(input int i);
        wait_ready("vec");
        drive_load(i);
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        chk("vec_ready_drop", 32'(LOAD_READY), 32'd0);
        wait_fd("vec");
        chk("vec_ready_low_at_fd", 32'(LOAD_READY), 32'd0);
        @(negedge CLK);
        chk("vec_ready_back", 32'(LOAD_READY), 32'd1);
        check_frame("vec_frame");
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0100, {8'h06, 8'hDB, 8'h4F, 8'h66}};
        tbl[1] = '{16'hABCD, 4'b0000, {8'h77, 8'h7C, 8'h39, 8'h5E}};
        tbl[2] = '{16'h5F80, 4'b1001, {8'hED, 8'h71, 8'h7F, 8'hBF}};
        tbl[3] = '{16'h9E67, 4'b0010, {8'h6F, 8'h79, 8'hFD, 8'h27}};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        tbl[4] = '{16'h0050, 4'b0000, {8'h00, 8'h00, 8'h6D, 8'h3F}};
        tbl[5] = '{16'h0000, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h3F}};
        tbl[6] = '{16'h0003, 4'b0100, {8'h00, 8'hBF, 8'h00, 8'h4F}};
`else
        tbl[4] = '{16'h0050, 4'b0000, {8'h3F, 8'h3F, 8'h6D, 8'h3F}};
        tbl[5] = '{16'h0000, 4'b0000, {8'h3F, 8'h3F, 8'h3F, 8'h3F}};
        tbl[6] = '{16'h0003, 4'b0100, {8'h3F, 8'hBF, 8'h3F, 8'h4F}};
`endif
        tbl[7] = '{16'h2468, 4'b0001, {8'h5B, 8'h66, 8'h7D, 8'hFF}};
        tbl[8] = '{16'h7531, 4'b0000, {8'h27, 8'h6D, 8'h4F, 8'h06}};
        tbl[9] = '{16'hBEEF, 4'b0000, {8'h7C, 8'h79, 8'h79, 8'h71}};

        RST_N      = 1'b0;
        ENABLE     = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = 16'h0000;
        LOAD_DP    = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 32'({FRAME_DONE, LOAD_READY, DIGIT_SEL, SEGMENT}), 32'h0000_1000);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_dark", 32'({FRAME_DONE, DIGIT_SEL, SEGMENT}), 32'd0);

        // Enable with zero value: two frames of timing trace
        ENABLE = 1'b1;
        for (int n = 1; n <= 2 * FRAME + 1; n++) begin
            int          slot;
            int          pos;
            logic [31:0] exp;
            @(negedge CLK);
            slot = ((n - 1) / DWELL) % 4;
            pos  = (n - 1) % DWELL;
            if (pos < BLANK) exp = 32'd0;
            else exp = 32'({(n % FRAME == 0), 4'(1 << slot), tbl[5].seg[slot]});
            chk("trace", 32'({FRAME_DONE, DIGIT_SEL, SEGMENT}), exp);
        end

        // Table-driven load/show vectors
        for (int i = 0; i <= 6; i++) begin
            load_vec(i);
        end

        // Second value held while ready is low is not captured early
        @(negedge CLK);
        chk("hold_ready_start", 32'(LOAD_READY), 32'd1);
        drive_load(7);
        @(negedge CLK);
        chk("hold_ready_drop", 32'(LOAD_READY), 32'd0);
        drive_load(8);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("hold_ready_stays_low", 32'(LOAD_READY), 32'd0);
        end
        wait_fd("hold");
        @(negedge CLK);
        chk("hold_ready_back", 32'(LOAD_READY), 32'd1);
        check_frame("hold_first_value");
        @(negedge CLK);
        chk("hold_ready_after_second", 32'(LOAD_READY), 32'd1);
        check_frame("hold_second_value");

        // Load landing on the FRAME_DONE cycle waits a full frame
        chk("fdload_at_fd", 32'({FRAME_DONE, LOAD_READY}), 32'd3);
        sb_q.push_back(tbl[8].seg);
        drive_load(9);
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        chk("fdload_ready_drop", 32'(LOAD_READY), 32'd0);
        check_frame("fdload_old_value");
        @(negedge CLK);
        chk("fdload_ready_back", 32'(LOAD_READY), 32'd1);
        check_frame("fdload_new_value");

        // Drop ENABLE in digit 2 DRIVE, load while idle, re-enable
        repeat (2 * DWELL + BLANK + 4) @(negedge CLK);
        chk("dis_in_digit2", 32'({DIGIT_SEL, SEGMENT}), 32'({4'b0100, tbl[9].seg[2]}));
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("dis_dark", 32'({FRAME_DONE, DIGIT_SEL, SEGMENT}), 32'd0);
        chk("idle_ready", 32'(LOAD_READY), 32'd1);
        drive_load(1);
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        chk("idle_ready_drop", 32'(LOAD_READY), 32'd0);
        @(negedge CLK);
        chk("idle_promote_ready", 32'(LOAD_READY), 32'd1);
        chk("idle_still_dark", 32'({FRAME_DONE, DIGIT_SEL, SEGMENT}), 32'd0);
        ENABLE = 1'b1;
        @(negedge CLK);
        check_frame("reenable_frame");

        // Reset mid-frame with a pending shadow value
        repeat (DWELL + 5) @(negedge CLK);
        chk("rst_ready_before", 32'(LOAD_READY), 32'd1);
        LOAD_DATA  = tbl[3].data;
        LOAD_DP    = tbl[3].dp;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        chk("rst_pending_load", 32'(LOAD_READY), 32'd0);
        RST_N = 1'b0;
        #1;
        chk("rst_async_outputs", 32'({FRAME_DONE, LOAD_READY, DIGIT_SEL, SEGMENT}), 32'h0000_1000);
        sb_q.push_back(tbl[5].seg);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_ready_after", 32'(LOAD_READY), 32'd1);
        check_frame("rst_zero_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
